ws2812_chain_driver: RTL and testbench
======================================

# ws2812_chain_driver

Frame-based WS2812/SK6812 serial LED driver for a chain of `LED_CNT` pixels, each `BITS_PER_LED` bits wide (24 = RGB, 32 = RGBW). It replaces free-running bit streaming with a start/ready handshake, a per-frame snapshot of the pixel data, and a guaranteed latch (reset) low period after every frame. It sits between the pixel register file / pattern generator and the `led_o` pad.

## Interface

Parameters:
- `CLK_SPEED`, 25_000_000: clock frequency, Hz.
- `LED_CNT`, 3: pixels in the chain, ≥1.
- `BITS_PER_LED`, 24: bits per pixel, 24 or 32.
- `TBIT_NS`, 1250: bit period, ns.
- `T0H_NS`, 400: high time of a 0 bit, ns.
- `T1H_NS`, 800: high time of a 1 bit, ns.
- `TLATCH_US`, 80: low time after a frame, µs.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `data` in LED_CNT*BITS_PER_LED: pixel data; pixel i is `data[(i+1)*BITS_PER_LED-1 : i*BITS_PER_LED]`.
- `start` in 1: request a frame.
- `auto_refresh` in 1: when high, restart automatically after each latch.
- `ready` out 1: high in IDLE; a frame is accepted when `start && ready` at a rising edge.
- `busy` out 1: equal to `!ready`.
- `frame_done` out 1: one-cycle pulse at the end of the latch period.
- `led_o` out 1: serial output, registered.

## Operation

- Derived counts use integer truncation: `CNT_BIT = CLK_SPEED*TBIT_NS/1e9`, `CNT_0H`, `CNT_1H` and `CNT_LATCH = CLK_SPEED*TLATCH_US/1e6`. Counter widths are `$clog2` of each count plus 1. Elaboration fails unless `1 ≤ CNT_0H < CNT_1H < CNT_BIT`.
- FSM states: IDLE, SEND, LATCH.
- IDLE: `ready=1`. On `start`, copy `data` into a snapshot register, clear the bit index and bit counter, and go to SEND. Changes to `data` after this edge do not affect the frame.
- SEND: bit order is pixel 0 first, MSB first within each pixel. The bit counter runs 0..CNT_BIT-1. `led_o` is high while counter < (bit ? CNT_1H : CNT_0H) and low otherwise. After the last bit (index LED_CNT*BITS_PER_LED-1, counter CNT_BIT-1), go to LATCH.
- LATCH: `led_o=0` for CNT_LATCH cycles. At the last cycle, pulse `frame_done`.
  - If `auto_refresh` is high, take a new snapshot and go directly to SEND. `ready` stays low.
  - Otherwise go to IDLE.
- `start` while busy is ignored; there is no queuing.
- Reset values: IDLE, `ready=1`, `busy=0`, `frame_done=0`, `led_o=0`, counters 0, snapshot 0.
- A reset mid-frame forces `led_o=0` on the next edge and abandons the frame. No `frame_done` is issued.

## Timing

- Accepting edge E0 (IDLE, `start=1`): the FSM enters SEND at E0. `led_o` goes high at E1.
- Each bit lasts exactly CNT_BIT cycles. The high phase lasts exactly CNT_0H or CNT_1H cycles. There are no gap cycles between bits or between pixels.
- Frame length from E1 to the fall of `frame_done` is LED_CNT*BITS_PER_LED*CNT_BIT + CNT_LATCH cycles.
- `frame_done` and `ready` rise on the same edge when `auto_refresh=0`. A `start` sampled in that cycle is accepted on the following edge.
- With `auto_refresh=1`, the next frame's first high begins one cycle after the `frame_done` cycle. The snapshot is taken at the `frame_done` edge.
- `led_o` is glitch-free: it comes straight from a flop with no combinational path from `data`.

## Structure

- Shared package `ws2812_pkg` holds:
  - the FSM state enum;
  - the `ns_to_cycles`/`us_to_cycles` constant functions;
  - the legality-check constants.
- Sub-module `ws2812_bit_timer` owns the bit counter and high-phase compare. Its inputs are `bit_val` and `run`; its outputs are `bit_end` and the `high` level. The top level owns the FSM, snapshot, bit index, latch counter and handshake.

## Test plan

All scenarios use the defaults (25 MHz): CNT_BIT=31, CNT_0H=10, CNT_1H=20, CNT_LATCH=2000.

- Single frame, `data=0x800001_000000_FFFFFF`, pulse `start`:
  - Bits are checked on the wire in order: pixel 0 bits are 1 (high 20 cycles each), pixel 1 bits are 0 (high 10 each), pixel 2 bits are MSB 1, then zeros, LSB 1.
  - Every period is 31 cycles.
  - `frame_done` arrives 72*31+2000 cycles after E1.
- `data` is changed every cycle during SEND -> the transmitted stream equals the value at E0.
- `start` held high continuously with `auto_refresh=0`:
  - Frames are back to back, each separated by exactly 2000 low cycles plus one handshake cycle.
  - `ready` is high only for 1 cycle between frames.
- `auto_refresh=1`: three consecutive frames with no IDLE state, and `ready` stays low throughout. Deasserting `auto_refresh` mid-frame returns to IDLE after that frame's latch.
- `reset` asserted during the bit 37 high phase -> `led_o=0` and `ready=1` on the next edge, and no `frame_done`. A subsequent `start` sends a complete fresh frame.
- `BITS_PER_LED=32`, `LED_CNT=1`, `data=0xA5A5A5A5` -> 32 bits with the correct high times. Illegal timing (`T0H_NS=1300`) -> elaboration error.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ws2812 chain driver: shared state encoding and timing helpers.
// Cycle counts are derived from clock frequency at elaboration time.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LATCH
    } state_t;

    localparam int MIN_HIGH_CYCLES  = 1;
    localparam int MIN_LATCH_CYCLES = 1;

    function automatic int ns_to_cycles(input int hz, input int ns);
        longint prod;
        prod = longint'(hz) * longint'(ns);
        return int'(prod / 64'sd1_000_000_000);
    endfunction

    function automatic int us_to_cycles(input int hz, input int us);
        longint prod;
        prod = longint'(hz) * longint'(us);
        return int'(prod / 64'sd1_000_000);
    endfunction

    function automatic bit timing_ok(
        input int c0h,
        input int c1h,
        input int cbit,
        input int clatch
    );
        return (c0h >= MIN_HIGH_CYCLES) && (c0h < c1h) &&
               (c1h < cbit) && (clatch >= MIN_LATCH_CYCLES);
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit cycle counter; reports the high phase level and the last
// cycle of each bit period while run is asserted.
module ws2812_bit_timer #(
    parameter int CNT_BIT = 31,
    parameter int CNT_0H  = 10,
    parameter int CNT_1H  = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic bit_val,
    output logic bit_end,
    output logic high
);

    localparam int CW = $clog2(CNT_BIT) + 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] high_len;

    assign high_len = bit_val ? CW'(CNT_1H) : CW'(CNT_0H);
    assign bit_end  = run && (cnt == CW'(CNT_BIT - 1));
    assign high     = run && (cnt < high_len);

    always_ff @(posedge clk) begin
        if (reset || !run || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ws2812_chain_driver.sv
// Frame-based WS2812/SK6812 chain driver with start/ready handshake,
// per-frame data snapshot and a guaranteed latch period.
module ws2812_chain_driver
    import ws2812_pkg::*;
#(
    parameter int CLK_SPEED    = 25_000_000,
    parameter int LED_CNT      = 3,
    parameter int BITS_PER_LED = 24,
    parameter int TBIT_NS      = 1250,
    parameter int T0H_NS       = 400,
    parameter int T1H_NS       = 800,
    parameter int TLATCH_US    = 80
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [LED_CNT*BITS_PER_LED-1:0] data,
    input  logic                            start,
    input  logic                            auto_refresh,
    output logic                            ready,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            led_o
);

    localparam int CNT_BIT   = ns_to_cycles(CLK_SPEED, TBIT_NS);
    localparam int CNT_0H    = ns_to_cycles(CLK_SPEED, T0H_NS);
    localparam int CNT_1H    = ns_to_cycles(CLK_SPEED, T1H_NS);
    localparam int CNT_LATCH = us_to_cycles(CLK_SPEED, TLATCH_US);
    localparam int N         = LED_CNT * BITS_PER_LED;
    localparam int IW        = $clog2(N) + 1;
    localparam int LW        = $clog2(CNT_LATCH) + 1;

    if (!timing_ok(CNT_0H, CNT_1H, CNT_BIT, CNT_LATCH)) begin : g_bad_timing
        $error("ws2812_chain_driver: illegal bit/latch timing");
    end
    if (BITS_PER_LED != 24 && BITS_PER_LED != 32) begin : g_bad_width
        $error("ws2812_chain_driver: BITS_PER_LED must be 24 or 32");
    end

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  shreg;
    logic [N-1:0]  ordered;
    logic [IW-1:0] idx;
    logic [LW-1:0] lcnt;
    logic          run;
    logic          bit_end;
    logic          high;
    logic          last_bit;
    logic          latch_end;
    logic          load;

    // Snapshot is stored in wire order: pixel 0 MSB ends up at the top.
    always_comb begin
        ordered = '0;
        for (int i = 0; i < LED_CNT; i++) begin
            ordered[(LED_CNT-i)*BITS_PER_LED-1 -: BITS_PER_LED] =
                data[i*BITS_PER_LED +: BITS_PER_LED];
        end
    end

    assign run       = (state == SEND);
    assign last_bit  = bit_end && (idx == IW'(N - 1));
    assign latch_end = (state == LATCH) && (lcnt == LW'(CNT_LATCH - 1));
    assign ready     = (state == IDLE);
    assign busy      = !ready;

    ws2812_bit_timer #(
        .CNT_BIT (CNT_BIT),
        .CNT_0H  (CNT_0H),
        .CNT_1H  (CNT_1H)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .bit_val (shreg[N-1]),
        .bit_end (bit_end),
        .high    (high)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SEND;
                    load     = 1'b1;
                end
            end
            SEND: begin
                if (last_bit) state_nx = LATCH;
            end
            LATCH: begin
                if (latch_end) begin
                    if (auto_refresh) begin
                        state_nx = SEND;
                        load     = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            idx        <= '0;
            lcnt       <= '0;
            frame_done <= 1'b0;
            led_o      <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= latch_end;
            led_o      <= high;
            if (load) begin
                shreg <= ordered;
                idx   <= '0;
            end else if (bit_end) begin
                shreg <= shreg << 1;
                idx   <= idx + IW'(1);
            end
            if (state == LATCH && !latch_end) begin
                lcnt <= lcnt + LW'(1);
            end else begin
                lcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Directed bench for ws2812_chain_driver: decodes the led_o waveform
// cycle by cycle and checks stream content, bit timing and handshake.
module tb_ws2812_chain_driver;

    localparam int NB1      = 72;
    localparam int NB2      = 32;
    localparam int CBIT     = 31;
    localparam int CLATCH   = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] data;
    logic        start;
    logic        auto_refresh;
    logic        ready, busy, frame_done, led_o;
    logic [31:0] data2;
    logic        start2;
    logic        auto2;
    logic        ready2, busy2, frame_done2, led_o2;

    int checks = 0;
    int errors = 0;

    always #20 clk = !clk;

    ws2812_chain_driver dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .start        (start),
        .auto_refresh (auto_refresh),
        .ready        (ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .led_o        (led_o)
    );

    ws2812_chain_driver #(
        .LED_CNT      (1),
        .BITS_PER_LED (32)
    ) dut32 (
        .clk          (clk),
        .reset        (reset),
        .data         (data2),
        .start        (start2),
        .auto_refresh (auto2),
        .ready        (ready2),
        .busy         (busy2),
        .frame_done   (frame_done2),
        .led_o        (led_o2)
    );

    typedef struct {
        logic [71:0] din;
        logic [71:0] exp;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input logic [71:0] act,
                         input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic led_s(input bit sel);
        return sel ? led_o2 : led_o;
    endfunction

    function automatic logic rdy_s(input bit sel);
        return sel ? ready2 : ready;
    endfunction

    function automatic logic done_s(input bit sel);
        return sel ? frame_done2 : frame_done;
    endfunction

    // Samples on falling edges. Sample 0 is the first high of the frame;
    // done_at is the sample index at which frame_done is seen high.
    task automatic rx_frame(
        input  bit          sel,
        input  int          nbits,
        output logic [71:0] stream,
        output int          bad,
        output int          w,
        output int          done_at,
        output int          rdy_seen,
        output logic        rdy_at_done
    );
        int idx;
        stream = '0;
        bad = 0;
        w = 0;
        done_at = -1;
        rdy_seen = 0;
        rdy_at_done = 1'b0;
        do begin
            @(negedge clk);
            w++;
            if (rdy_s(sel) === 1'b1) rdy_seen++;
        end while (led_s(sel) !== 1'b1 && w < 100);
        if (led_s(sel) !== 1'b1) begin
            bad = 999;
            return;
        end
        for (int b = 0; b < nbits; b++) begin
            int h;
            h = 0;
            for (int c = 0; c < CBIT; c++) begin
                if (b != 0 || c != 0) begin
                    @(negedge clk);
                    if (rdy_s(sel) === 1'b1) rdy_seen++;
                end
                if (done_s(sel) !== 1'b0) bad++;
                if (led_s(sel) === 1'b1) begin
                    if (h != c) bad++;
                    h++;
                end
            end
            if (h != 10 && h != 20) bad++;
            stream = {stream[70:0], h == 20};
        end
        idx = nbits * CBIT - 1;
        while (done_s(sel) !== 1'b1 && idx < nbits * CBIT + CLATCH + 100) begin
            @(negedge clk);
            idx++;
            if (led_s(sel) !== 1'b0) bad++;
            if (done_s(sel) !== 1'b1 && rdy_s(sel) === 1'b1) rdy_seen++;
        end
        if (done_s(sel) === 1'b1) begin
            done_at = idx;
            rdy_at_done = rdy_s(sel);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [71:0] st;
    logic        rad;
    int          bad, w, dat, rs, seen;
    logic [95:0] r;

    initial begin
        vecs[0].din = 72'h800001_000000_FFFFFF;
        vecs[0].exp = 72'hFFFFFF_000000_800001;
        vecs[1].din = 72'h123456_ABCDEF_0F0F0F;
        vecs[1].exp = 72'h0F0F0F_ABCDEF_123456;
        vecs[2].din = 72'h000000_000000_000001;
        vecs[2].exp = 72'h000001_000000_000000;
        vecs[3].din = 72'hFFFFFF_FFFFFF_FFFFFF;
        vecs[3].exp = 72'hFFFFFF_FFFFFF_FFFFFF;

        reset = 1'b1;
        data = '0;
        start = 1'b0;
        auto_refresh = 1'b0;
        data2 = '0;
        start2 = 1'b0;
        auto2 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", int'({ready, busy, frame_done, led_o}), 8);

        for (int i = 0; i < 4; i++) begin
            data = vecs[i].din;
            pulse_start();
            rx_frame(1'b0, NB1, st, bad, w, dat, rs, rad);
            chk_s($sformatf("v%0d_stream", i), st, vecs[i].exp);
            chk($sformatf("v%0d_timing", i), bad, 0);
            chk($sformatf("v%0d_e1", i), w, 1);
            chk($sformatf("v%0d_done_at", i), dat, NB1 * CBIT + CLATCH - 1);
            chk($sformatf("v%0d_ready_done", i), int'(rad), 1);
            chk($sformatf("v%0d_busy_frame", i), rs, 0);
        end

        data = vecs[1].din;
        pulse_start();
        fork
            rx_frame(1'b0, NB1, st, bad, w, dat, rs, rad);
            begin
                repeat (NB1 * CBIT) begin
                    @(negedge clk);
                    r = {$urandom, $urandom, $urandom};
                    data = r[71:0];
                end
            end
        join
        chk_s("snapshot_stream", st, vecs[1].exp);
        chk("snapshot_timing", bad, 0);

        data = vecs[0].din;
        start = 1'b1;
        @(negedge clk);
        rx_frame(1'b0, NB1, st, bad, w, dat, rs, rad);
        chk("held_f1_ready_done", int'(rad), 1);
        fork
            rx_frame(1'b0, NB1, st, bad, w, dat, rs, rad);
            begin
                repeat (10) @(negedge clk);
                start = 1'b0;
            end
        join
        chk("held_f2_gap", w, 2);
        chk("held_f2_ready", rs, 0);
        chk_s("held_f2_stream", st, vecs[0].exp);
        chk("held_f2_done_at", dat, NB1 * CBIT + CLATCH - 1);

        auto_refresh = 1'b1;
        data = vecs[2].din;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            fork
                rx_frame(1'b0, NB1, st, bad, w, dat, rs, rad);
                begin
                    if (f == 2) begin
                        repeat (100) @(negedge clk);
                        auto_refresh = 1'b0;
                    end
                end
            join
            chk_s($sformatf("auto_f%0d_stream", f), st, vecs[2].exp);
            chk($sformatf("auto_f%0d_timing", f), bad, 0);
            chk($sformatf("auto_f%0d_e1", f), w, 1);
            chk($sformatf("auto_f%0d_ready", f), rs, 0);
            chk($sformatf("auto_f%0d_done_at", f), dat, NB1 * CBIT + CLATCH - 1);
            chk($sformatf("auto_f%0d_ready_done", f), int'(rad), f == 2 ? 1 : 0);
        end
        @(negedge clk);
        chk("auto_idle_after", int'({ready, led_o}), 2);

        data = vecs[0].din;
        pulse_start();
        w = 0;
        while (led_o !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (37 * CBIT + 4) @(negedge clk);
        chk("bit37_high", int'(led_o), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_frame", int'({led_o, ready, frame_done}), 2);
        reset = 1'b0;
        seen = 0;
        repeat (NB1 * CBIT + CLATCH + 50) begin
            @(negedge clk);
            if (frame_done === 1'b1 || led_o === 1'b1) seen++;
        end
        chk("no_done_after_reset", seen, 0);
        data = vecs[1].din;
        pulse_start();
        rx_frame(1'b0, NB1, st, bad, w, dat, rs, rad);
        chk_s("post_reset_stream", st, vecs[1].exp);
        chk("post_reset_timing", bad, 0);
        chk("post_reset_done_at", dat, NB1 * CBIT + CLATCH - 1);

        data2 = 32'hA5A5A5A5;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        rx_frame(1'b1, NB2, st, bad, w, dat, rs, rad);
        chk_s("rgbw_stream", st, 72'h00_0000_0000_A5A5A5A5);
        chk("rgbw_timing", bad, 0);
        chk("rgbw_done_at", dat, NB2 * CBIT + CLATCH - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
